// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared constants and types for the PWM peripheral slice.
//   PWM_CNT_W : width of the period counter (one period = 2**PWM_CNT_W counts)
//   NUM_CH    : number of output channels
//   DUTY_FULL : duty code that means "always on" (100 %)
package pwm_pkg;

   localparam int PWM_CNT_W = 8;
   localparam int NUM_CH    = 16;

   typedef logic [PWM_CNT_W-1:0] duty_t;

   localparam duty_t DUTY_FULL = 8'hFF;

endpackage : pwm_pkg

// File: rtl/pwm_timebase.sv
// pwm_timebase
// Free-running prescaler plus 8-bit period counter shared by all channels.
// The counter advances once every CLK_DIV clk cycles and wraps 255 -> 0
// without stalling, so one PWM period is 256 * CLK_DIV clk cycles.
//
// Parameters
//   CLK_DIV           clk cycles per count (>= 1)
// Ports
//   clk               system clock, rising edge
//   rst               asynchronous active-high reset
//   cnt               current count within the period
//   wrap              last clk cycle of the period (tick while cnt == 255)
//   period_start_cond first clk cycle of the period (pre == 0, cnt == 0)
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = 13
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [PWM_CNT_W-1:0] cnt,
   output logic                 wrap,
   output logic                 period_start_cond
);

   // $clog2(1) is 0; keep at least one bit so the prescaler always exists.
   localparam int              PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

   logic [PRE_W-1:0]     pre_reg;
   logic [PWM_CNT_W-1:0] cnt_reg;
   logic                 tick;

   // With CLK_DIV == 1 the prescaler sits at 0 and tick is high every cycle.
   assign tick = (pre_reg == PRE_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_reg <= '0;
         cnt_reg <= '0;
      end else begin
         pre_reg <= tick ? '0 : pre_reg + 1'b1;
         if (tick) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign cnt               = cnt_reg;
   assign wrap              = tick && (cnt_reg == '1);
   assign period_start_cond = (pre_reg == '0) && (cnt_reg == '0);

endmodule : pwm_timebase

// File: rtl/pwm_peripheral.sv
// pwm_peripheral
// Drives 16 output pins from the SPI configuration registers. Each pin is
// off, statically on, or PWM-modulated by one shared 8-bit duty cycle on a
// common timebase.
//
// Build option (macro PWM_DUTY_SHADOW_EN):
//   defined   - duty is taken from a shadow register that reloads from
//               pwm_duty_cycle only at the period boundary, so a period is
//               never cut short or stretched by a mid-period write.
//   undefined - duty is used directly; a change shows on out one clk later.
//
// Parameters
//   CLK_DIV          clk cycles per PWM count (>= 1)
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   en_reg_out_7_0   output enable, channels 7..0
//   en_reg_out_15_8  output enable, channels 15..8
//   en_reg_pwm_7_0   PWM mode select, channels 7..0
//   en_reg_pwm_15_8  PWM mode select, channels 15..8
//   pwm_duty_cycle   shared duty, 0x00 = 0 %, 0xFF = 100 %
//   out              registered channel outputs
//   period_start     one-cycle pulse marking count 0 of each period
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        en_reg_out_7_0,
   input  logic [7:0]        en_reg_out_15_8,
   input  logic [7:0]        en_reg_pwm_7_0,
   input  logic [7:0]        en_reg_pwm_15_8,
   input  logic [7:0]        pwm_duty_cycle,
   output logic [NUM_CH-1:0] out,
   output logic              period_start
);

   logic [PWM_CNT_W-1:0] cnt;
   logic                 wrap;
   logic                 period_start_cond;
   duty_t                duty_eff;
   logic                 lvl;
   logic [NUM_CH-1:0]    en_out;
   logic [NUM_CH-1:0]    en_pwm;
   logic [NUM_CH-1:0]    out_next;
   logic [NUM_CH-1:0]    out_reg;
   logic                 period_start_reg;

   pwm_timebase #(
      .CLK_DIV (CLK_DIV)
   ) u_timebase (
      .clk               (clk),
      .rst               (rst),
      .cnt               (cnt),
      .wrap              (wrap),
      .period_start_cond (period_start_cond)
   );

`ifdef PWM_DUTY_SHADOW_EN
   duty_t duty_shadow_reg;

   // Reloading on the last cycle of a period makes the new duty apply from
   // cnt == 0; a write landing exactly on that cycle is still captured.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_shadow_reg <= '0;
      end else if (wrap) begin
         duty_shadow_reg <= pwm_duty_cycle;
      end
   end

   assign duty_eff = duty_shadow_reg;
`else
   // Without the shadow the period boundary has no consumer.
   logic unused_wrap;
   assign unused_wrap = wrap;
   assign duty_eff    = pwm_duty_cycle;
`endif

   // 0xFF is forced fully on; any other N gives N high counts out of 256.
   assign lvl = (duty_eff == DUTY_FULL) ? 1'b1 : (cnt < duty_eff);

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign out_next[gi] = en_out[gi] & (en_pwm[gi] ? lvl : 1'b1);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_reg          <= '0;
         period_start_reg <= 1'b0;
      end else begin
         out_reg          <= out_next;
         period_start_reg <= period_start_cond;
      end
   end

   assign out          = out_reg;
   assign period_start = period_start_reg;

endmodule : pwm_peripheral

// File: tb/tb_pwm_peripheral.sv
// Testbench for pwm_peripheral with CLK_DIV = 2 (512-cycle period).
// Honours PWM_DUTY_SHADOW_EN the same way the design does.
module tb_pwm_peripheral;

   localparam int CLK_DIV = 2;
   localparam int PERIOD  = 256 * CLK_DIV;
`ifdef PWM_DUTY_SHADOW_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] en_out = '0;
   logic [15:0] en_pwm = '0;
   logic [7:0]  duty = '0;
   logic [15:0] out;
   logic        period_start;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pwm_peripheral #(
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .en_reg_out_7_0  (en_out[7:0]),
      .en_reg_out_15_8 (en_out[15:8]),
      .en_reg_pwm_7_0  (en_pwm[7:0]),
      .en_reg_pwm_15_8 (en_pwm[15:8]),
      .pwm_duty_cycle  (duty),
      .out             (out),
      .period_start    (period_start)
   );

   // ---------------- reference model ----------------
   // k counts clk edges since reset release; count and period position are
   // derived from k arithmetically.
   int unsigned m_k;
   logic [7:0]  m_shadow;
   logic [15:0] exp_out;
   logic        exp_ps;

   function automatic logic [15:0] model_out(int unsigned k, logic [7:0] d,
                                             logic [15:0] eo, logic [15:0] ep);
      int unsigned c;
      logic        l;
      c = (k / CLK_DIV) % 256;
      l = (d == 8'hFF) ? 1'b1 : (c < int'(d));
      return eo & (~ep | {16{l}});
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_k      <= 0;
         m_shadow <= 8'h00;
         exp_out  <= 16'h0000;
         exp_ps   <= 1'b0;
      end else begin
         exp_out <= model_out(m_k, SHADOW ? m_shadow : duty, en_out, en_pwm);
         exp_ps  <= ((m_k % PERIOD) == 0);
         if ((m_k % PERIOD) == PERIOD - 1) m_shadow <= duty;
         m_k <= m_k + 1;
      end
   end

   // Leaves the bench at the negedge of release; the next edge is k = 0.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int n;
      en_out = 16'hFFFF; en_pwm = 16'h0000; duty = 8'h00;
      do_reset();
      repeat (300) @(negedge clk);
      n_checks++;
      if (out !== 16'hFFFF) begin
         n_fail++; $display("FAIL pre_reset_out: got %h expected %h", out, 16'hFFFF);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (out !== 16'h0000 || period_start !== 1'b0) begin
         n_fail++; $display("FAIL async_reset: out %h ps %b expected 0000 0", out, period_start);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (out !== 16'h0000 || period_start !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold: out %h ps %b expected 0000 0", out, period_start);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (period_start !== 1'b1) begin
         n_fail++; $display("FAIL first_period_start: got %b expected 1", period_start);
      end
      n = 0;
      for (int i = 1; i <= 1000; i++) begin
         @(negedge clk);
         if (period_start === 1'b1) begin n = i; break; end
      end
      n_checks++;
      if (n != PERIOD) begin
         n_fail++; $display("FAIL period_start_spacing: got %0d expected %0d", n, PERIOD);
      end
      $display("test_reset done");
   endtask

   task automatic test_static();
      @(negedge clk);
      en_out = 16'hFFFF; en_pwm = 16'h0000;
      @(negedge clk);
      n_checks++;
      if (out !== 16'hFFFF) begin
         n_fail++; $display("FAIL static_all_on: got %h expected %h", out, 16'hFFFF);
      end
      en_out = 16'h00F0;
      @(negedge clk);
      n_checks++;
      if (out !== 16'h00F0) begin
         n_fail++; $display("FAIL static_00f0: got %h expected %h", out, 16'h00F0);
      end
      $display("test_static done");
   endtask

   task automatic test_pwm_half();
      int h0, h1, other;
      en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
      do_reset();
      h0 = 0; h1 = 0; other = 0;
      for (int j = 0; j < 2 * PERIOD; j++) begin
         @(negedge clk);
         if (out[0] === 1'b1) begin
            if (j < PERIOD) h0++; else h1++;
         end
         if (out[15:1] !== 15'h0) other++;
      end
      n_checks++;
      if (h0 != (SHADOW ? 0 : 256)) begin
         n_fail++; $display("FAIL half_period0_highs: got %0d expected %0d", h0, SHADOW ? 0 : 256);
      end
      n_checks++;
      if (h1 != 256) begin
         n_fail++; $display("FAIL half_period1_highs: got %0d expected 256", h1);
      end
      n_checks++;
      if (other != 0) begin
         n_fail++; $display("FAIL half_other_bits: got %0d cycles nonzero expected 0", other);
      end
      $display("test_pwm_half done");
   endtask

   task automatic test_duty_extremes();
      logic [7:0] dv [2];
      int highs, toggles;
      logic prev;
      dv[0] = 8'h00; dv[1] = 8'hFF;
      for (int t = 0; t < 2; t++) begin
         en_out = 16'h0001; en_pwm = 16'h0001; duty = dv[t];
         do_reset();
         repeat (PERIOD) @(negedge clk);
         highs = 0; toggles = 0; prev = out[0];
         for (int j = 0; j < 2 * PERIOD; j++) begin
            @(negedge clk);
            if (out[0] === 1'b1) highs++;
            if (j > 0 && out[0] !== prev) toggles++;
            prev = out[0];
         end
         n_checks++;
         if (highs != (t == 0 ? 0 : 2 * PERIOD)) begin
            n_fail++; $display("FAIL extreme_highs duty %h: got %0d expected %0d", dv[t], highs, t == 0 ? 0 : 2 * PERIOD);
         end
         n_checks++;
         if (toggles != 0) begin
            n_fail++; $display("FAIL extreme_glitch duty %h: got %0d toggles expected 0", dv[t], toggles);
         end
      end
      $display("test_duty_extremes done");
   endtask

   task automatic test_duty_change();
      int h1, h2;
      logic at_change;
      en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h40;
      do_reset();
      repeat (PERIOD) @(negedge clk);
      h1 = 0; h2 = 0; at_change = 1'bx;
      for (int j = 0; j < 2 * PERIOD; j++) begin
         @(negedge clk);
         if (out[0] === 1'b1) begin
            if (j < PERIOD) h1++; else h2++;
         end
         if (j == 200) at_change = out[0];
         if (j == 199) duty = 8'hC0;  // next edge is cnt = 100, pre = 0
      end
      n_checks++;
      if (at_change !== (SHADOW ? 1'b0 : 1'b1)) begin
         n_fail++; $display("FAIL change_next_clk: got %b expected %b", at_change, SHADOW ? 1'b0 : 1'b1);
      end
      n_checks++;
      if (h1 != (SHADOW ? 128 : 312)) begin
         n_fail++; $display("FAIL change_same_period: got %0d expected %0d", h1, SHADOW ? 128 : 312);
      end
      n_checks++;
      if (h2 != 384) begin
         n_fail++; $display("FAIL change_next_period: got %0d expected 384", h2);
      end
      $display("test_duty_change done");
   endtask

   task automatic test_mixed();
      int h0, low15, other;
      en_out = 16'h8001; en_pwm = 16'h0001; duty = 8'h10;
      do_reset();
      repeat (PERIOD) @(negedge clk);
      h0 = 0; low15 = 0; other = 0;
      for (int j = 0; j < PERIOD; j++) begin
         @(negedge clk);
         if (out[0] === 1'b1) h0++;
         if (out[15] !== 1'b1) low15++;
         if (out[14:1] !== 14'h0) other++;
      end
      n_checks++;
      if (h0 != 32) begin
         n_fail++; $display("FAIL mixed_ch0_highs: got %0d expected 32", h0);
      end
      n_checks++;
      if (low15 != 0) begin
         n_fail++; $display("FAIL mixed_ch15_const: got %0d low cycles expected 0", low15);
      end
      n_checks++;
      if (other != 0) begin
         n_fail++; $display("FAIL mixed_other_bits: got %0d nonzero cycles expected 0", other);
      end
      $display("test_mixed done");
   endtask

   task automatic test_random();
      int shown;
      shown = 0;
      en_out = 16'($urandom); en_pwm = 16'($urandom); duty = 8'($urandom);
      do_reset();
      for (int j = 0; j < 3000; j++) begin
         @(negedge clk);
         n_checks++;
         if (out !== exp_out || period_start !== exp_ps) begin
            n_fail++;
            if (shown < 20) begin
               shown++;
               $display("FAIL random_cycle %0d: out %h ps %b expected %h %b", j, out, period_start, exp_out, exp_ps);
            end
         end
         if (j == 1500) rst = 1'b1;
         if (j == 1502) rst = 1'b0;
         if ($urandom_range(0, 99) < 3) duty = 8'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            en_out = 16'($urandom); en_pwm = 16'($urandom);
         end
      end
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_static();
      test_pwm_half();
      test_duty_extremes();
      test_duty_change();
      test_mixed();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pwm_peripheral
